// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU function codes, status codes, condition codes.
package y86_pkg;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] CMOV  = 4'h2;
  localparam logic [3:0] IRMOV = 4'h3;
  localparam logic [3:0] RMMOV = 4'h4;
  localparam logic [3:0] MRMOV = 4'h5;
  localparam logic [3:0] OPQ   = 4'h6;
  localparam logic [3:0] JXX   = 4'h7;
  localparam logic [3:0] CALL  = 4'h8;
  localparam logic [3:0] RET   = 4'h9;
  localparam logic [3:0] PUSH  = 4'hA;
  localparam logic [3:0] POP   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/y86_cond_eval.sv
// Condition evaluation for jXX/cmovXX from the registered condition codes; purely combinational.
module y86_cond_eval
  import y86_pkg::*;
(
  input  cc_t        cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic lt;

  always_comb begin
    lt  = cc.sf ^ cc.of;
    cnd = 1'b0;
    case (ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt | cc.zf;
      4'd2:    cnd = lt;
      4'd3:    cnd = cc.zf;
      4'd4:    cnd = ~cc.zf;
      4'd5:    cnd = ~lt;
      4'd6:    cnd = ~lt & ~cc.zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage_p.sv
// Y86-64 execute stage: ALU, condition codes, Cnd, and the E->M register; e_* same cycle, M_* one edge later.
// Define EXEC_MULQ_EN for an iterative shift-add mulq (OPq ifun 4) that asserts e_busy while running.
module execute_stage_p
  import y86_pkg::*;
#(
  parameter int               DATA_W = 64,
  parameter int               REG_W  = 4,
  parameter logic [REG_W-1:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [REG_W-1:0]  E_dstE,
  input  logic [REG_W-1:0]  E_dstM,
  input  logic [1:0]        m_stat,
  input  logic [1:0]        W_stat,
  input  logic              M_bubble,
  input  logic              M_stall,
  output logic [1:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [REG_W-1:0]  M_dstE,
  output logic [REG_W-1:0]  M_dstM,
  output logic              e_Cnd,
  output logic [DATA_W-1:0] e_valE,
  output logic [REG_W-1:0]  e_dstE,
  output logic              e_busy,
  output logic [2:0]        cc_out
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] EIGHT = DATA_W'(8);

  cc_t               cc_q, cc_d;
  logic              cc_we;
  logic              stat_ok, set_cc, is_mul, alu_of;
  logic [DATA_W-1:0] alu_val, sum_ab, diff_ba;
  logic [1:0]        m_stat_d;

  assign stat_ok = (m_stat == STAT_AOK) && (W_stat == STAT_AOK) && (E_stat == STAT_AOK);
  assign set_cc  = (E_icode == OPQ) && stat_ok;
  assign is_mul  = (E_icode == OPQ) && (E_ifun == ALU_MUL);
  assign sum_ab  = E_valA + E_valB;
  assign diff_ba = E_valB - E_valA;

  always_comb begin
    alu_val = '0;
    alu_of  = 1'b0;
    case (E_icode)
      OPQ: begin
        case (E_ifun)
          ALU_ADD: begin
            alu_val = sum_ab;
            alu_of  = (E_valA[MSB] == E_valB[MSB]) && (sum_ab[MSB] != E_valA[MSB]);
          end
          ALU_SUB: begin
            alu_val = diff_ba;
            alu_of  = (E_valA[MSB] != E_valB[MSB]) && (diff_ba[MSB] != E_valB[MSB]);
          end
          ALU_AND: alu_val = E_valA & E_valB;
          ALU_XOR: alu_val = E_valA ^ E_valB;
          default: alu_val = '0;
        endcase
      end
      IRMOV:        alu_val = E_valC;
      RMMOV, MRMOV: alu_val = E_valB + E_valC;
      CALL, PUSH:   alu_val = E_valB - EIGHT;
      RET, POP:     alu_val = E_valB + EIGHT;
      CMOV:         alu_val = E_valA;
      JXX:          alu_val = '0;
      default:      alu_val = '0;
    endcase
  end

`ifdef EXEC_MULQ_EN
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc, acc_next;
  logic              mul_start, b_bit;

  // The entry cycle already performs iteration 0, so e_busy covers exactly DATA_W cycles.
  assign mul_start = (state == S_IDLE) && is_mul && set_cc;
  assign b_bit     = |(E_valB & (DATA_W'(1) << cnt));
  assign acc_next  = ((state == S_IDLE) ? '0 : acc) + (b_bit ? (E_valA << cnt) : '0);
  assign e_busy    = mul_start || (state == S_BUSY);
  assign e_valE    = (state == S_DONE) ? acc : alu_val;
  assign m_stat_d  = E_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mul_start && !M_bubble) begin
            state <= S_BUSY;
            acc   <= acc_next;
            cnt   <= CNT_W'(1);
          end
        end
        S_BUSY: begin
          if (M_bubble) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) state <= S_DONE;
          end
        end
        S_DONE: begin
          cnt <= '0;
          if (M_bubble || !M_stall) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign e_busy   = 1'b0;
  assign e_valE   = alu_val;
  assign m_stat_d = is_mul ? STAT_INS : E_stat;
`endif

  always_comb begin
    cc_we   = set_cc && !is_mul;
    cc_d.zf = (alu_val == '0);
    cc_d.sf = alu_val[MSB];
    cc_d.of = alu_of;
`ifdef EXEC_MULQ_EN
    if (state == S_DONE) begin
      cc_we   = !M_bubble && !M_stall;
      cc_d.zf = (acc == '0);
      cc_d.sf = acc[MSB];
      cc_d.of = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    else if (cc_we) cc_q <= cc_d;
  end

  assign cc_out = cc_q;

  y86_cond_eval u_cond (
    .cc   (cc_q),
    .ifun (E_ifun),
    .cnd  (e_Cnd)
  );

  assign e_dstE = ((E_icode == CMOV) && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= INOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (M_bubble || (!M_stall && e_busy)) begin
      M_stat  <= STAT_AOK;
      M_icode <= INOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= m_stat_d;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage_p.sv
// Directed bench for execute_stage_p: reset, ALU/CC/Cnd, cmov, M stall/bubble, mulq in either build.
module tb_execute_stage_p;
  import y86_pkg::*;

  localparam logic [3:0] RN = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  E_stat = STAT_AOK, m_stat = STAT_AOK, W_stat = STAT_AOK;
  logic [3:0]  E_icode = INOP, E_ifun = 4'h0;
  logic [63:0] E_valC = '0, E_valA = '0, E_valB = '0;
  logic [3:0]  E_dstE = RN, E_dstM = RN;
  logic        M_bubble = 1'b0, M_stall = 1'b0;
  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        e_Cnd;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_busy;
  logic [2:0]  cc_out;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  execute_stage_p #(.DATA_W(64), .REG_W(4), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble), .M_stall(M_stall),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .e_Cnd(e_Cnd), .e_valE(e_valE), .e_dstE(e_dstE),
    .e_busy(e_busy), .cc_out(cc_out)
  );

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de);
    E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c; E_dstE = de; E_dstM = RN;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (M_icode !== INOP) begin fails++; $display("FAIL reset_icode got %h want %h", M_icode, INOP); end
    checks++; if (M_stat !== STAT_AOK) begin fails++; $display("FAIL reset_stat got %h want 0", M_stat); end
    checks++; if (M_dstE !== RN || M_dstM !== RN) begin fails++; $display("FAIL reset_dst got %h/%h want f/f", M_dstE, M_dstM); end
    checks++; if (M_valE !== 64'h0 || M_valA !== 64'h0 || M_Cnd !== 1'b0) begin fails++; $display("FAIL reset_vals got %h/%h/%b want 0", M_valE, M_valA, M_Cnd); end
    checks++; if (cc_out !== 3'b100) begin fails++; $display("FAIL reset_cc got %b want 100", cc_out); end
    checks++; if (e_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", e_busy); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_add_overflow;
    drive(OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2);
    #1;
    checks++; if (e_valE !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL add_valE got %h want 8000000000000000", e_valE); end
    tick;
    checks++; if (cc_out !== 3'b011) begin fails++; $display("FAIL add_cc got %b want 011", cc_out); end
    checks++; if (M_valE !== 64'h8000_0000_0000_0000 || M_icode !== OPQ || M_dstE !== 4'h2) begin fails++; $display("FAIL add_M got %h/%h/%h", M_valE, M_icode, M_dstE); end
    // SF=1, OF=1 means no signed less-than; ZF=0 -> le false, g true.
    drive(JXX, 4'd1, 64'h0, 64'h0, 64'h40, RN);
    #1;
    checks++; if (e_Cnd !== 1'b0) begin fails++; $display("FAIL jle_cnd got %b want 0", e_Cnd); end
    E_ifun = 4'd6; #1;
    checks++; if (e_Cnd !== 1'b1) begin fails++; $display("FAIL jg_cnd got %b want 1", e_Cnd); end
    E_ifun = 4'd2; #1;
    checks++; if (e_Cnd !== 1'b0) begin fails++; $display("FAIL jl_cnd got %b want 0", e_Cnd); end
    E_ifun = 4'd7; #1;
    checks++; if (e_Cnd !== 1'b0) begin fails++; $display("FAIL ifun7_cnd got %b want 0", e_Cnd); end
    tick;
  endtask

  task automatic test_sub_adr;
    drive(OPQ, ALU_SUB, 64'd3, 64'd10, 64'h0, 4'h1);
    m_stat = STAT_ADR;
    #1;
    checks++; if (e_valE !== 64'd7) begin fails++; $display("FAIL sub_valE got %h want 7", e_valE); end
    tick;
    m_stat = STAT_AOK;
    checks++; if (cc_out !== 3'b011) begin fails++; $display("FAIL sub_adr_cc got %b want 011", cc_out); end
    checks++; if (M_valE !== 64'd7) begin fails++; $display("FAIL sub_M_valE got %h want 7", M_valE); end
  endtask

  task automatic test_cmov;
    drive(OPQ, ALU_XOR, 64'd5, 64'd5, 64'h0, 4'h1);
    tick;
    checks++; if (cc_out !== 3'b100) begin fails++; $display("FAIL xor_cc got %b want 100", cc_out); end
    drive(CMOV, 4'd4, 64'h55, 64'h0, 64'h0, 4'h3);
    #1;
    checks++; if (e_Cnd !== 1'b0 || e_dstE !== RN) begin fails++; $display("FAIL cmovne got cnd=%b dst=%h want 0/f", e_Cnd, e_dstE); end
    checks++; if (e_valE !== 64'h55) begin fails++; $display("FAIL cmov_valE got %h want 55", e_valE); end
    tick;
    checks++; if (M_dstE !== RN || M_Cnd !== 1'b0) begin fails++; $display("FAIL cmovne_M got dst=%h cnd=%b want f/0", M_dstE, M_Cnd); end
    E_ifun = 4'd3; #1;
    checks++; if (e_Cnd !== 1'b1 || e_dstE !== 4'h3) begin fails++; $display("FAIL cmove got cnd=%b dst=%h want 1/3", e_Cnd, e_dstE); end
    tick;
  endtask

  task automatic test_stall_bubble;
    drive(IRMOV, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h2);
    tick;
    checks++; if (M_valE !== 64'h1234 || M_icode !== IRMOV) begin fails++; $display("FAIL irmov_M got %h/%h want 1234/3", M_valE, M_icode); end
    drive(RMMOV, 4'h0, 64'hAA, 64'h100, 64'h20, RN);
    M_stall = 1'b1;
    #1;
    checks++; if (e_valE !== 64'h120) begin fails++; $display("FAIL rmmov_valE got %h want 120", e_valE); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (M_valE !== 64'h1234 || M_icode !== IRMOV) begin fails++; $display("FAIL stall_hold%0d got %h/%h want 1234/3", i, M_valE, M_icode); end
    end
    M_bubble = 1'b1;
    tick;
    checks++; if (M_icode !== INOP || M_valE !== 64'h0 || M_dstE !== RN) begin fails++; $display("FAIL stall_bubble got %h/%h/%h want 1/0/f", M_icode, M_valE, M_dstE); end
    M_bubble = 1'b0;
    M_stall = 1'b0;
    tick;
    checks++; if (M_icode !== RMMOV || M_valE !== 64'h120 || M_valA !== 64'hAA) begin fails++; $display("FAIL after_stall got %h/%h/%h want 4/120/aa", M_icode, M_valE, M_valA); end
  endtask

  task automatic test_misc_alu;
    drive(CALL, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    #1;
    checks++; if (e_valE !== 64'hF8) begin fails++; $display("FAIL call_valE got %h want f8", e_valE); end
    drive(POP, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    #1;
    checks++; if (e_valE !== 64'h108) begin fails++; $display("FAIL pop_valE got %h want 108", e_valE); end
    drive(OPQ, ALU_AND, 64'hF0, 64'h3C, 64'h0, 4'h1);
    #1;
    checks++; if (e_valE !== 64'h30) begin fails++; $display("FAIL and_valE got %h want 30", e_valE); end
    tick;
    checks++; if (cc_out !== 3'b000) begin fails++; $display("FAIL and_cc got %b want 000", cc_out); end
  endtask

  task automatic test_mulq;
    drive(OPQ, ALU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 4'h5);
    #1;
`ifdef EXEC_MULQ_EN
    begin
      int n;
      int bad;
      n = 0;
      bad = 0;
      while (e_busy === 1'b1 && n < 200) begin
        n++;
        tick;
        if (M_icode !== INOP) bad++;
      end
      checks++; if (n != 64) begin fails++; $display("FAIL mul_busy_cycles got %0d want 64", n); end
      checks++; if (bad != 0) begin fails++; $display("FAIL mul_self_bubble got %0d non-NOP cycles want 0", bad); end
      checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFEB) begin fails++; $display("FAIL mul_done_valE got %h want ffffffffffffffeb", e_valE); end
      tick;
      drive(INOP, 4'h0, 64'h0, 64'h0, 64'h0, RN);
      checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFEB || M_icode !== OPQ || M_stat !== STAT_AOK) begin fails++; $display("FAIL mul_M got %h/%h/%h", M_valE, M_icode, M_stat); end
      checks++; if (cc_out !== 3'b010) begin fails++; $display("FAIL mul_cc got %b want 010", cc_out); end
      #1;
      checks++; if (e_busy !== 1'b0) begin fails++; $display("FAIL mul_idle_busy got %b want 0", e_busy); end
    end
`else
    checks++; if (e_busy !== 1'b0 || e_valE !== 64'h0) begin fails++; $display("FAIL mul_off_comb got busy=%b valE=%h want 0/0", e_busy, e_valE); end
    tick;
    drive(INOP, 4'h0, 64'h0, 64'h0, 64'h0, RN);
    checks++; if (M_stat !== STAT_INS || M_icode !== OPQ) begin fails++; $display("FAIL mul_off_stat got %h/%h want 3/6", M_stat, M_icode); end
    checks++; if (cc_out !== 3'b000) begin fails++; $display("FAIL mul_off_cc got %b want 000", cc_out); end
`endif
  endtask

  task automatic test_reset_midrun;
    drive(IRMOV, 4'h0, 64'h0, 64'h0, 64'h99, 4'h6);
    tick;
    checks++; if (M_valE !== 64'h99 || M_dstE !== 4'h6) begin fails++; $display("FAIL pre_reset_M got %h/%h want 99/6", M_valE, M_dstE); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (M_icode !== INOP || M_valE !== 64'h0 || M_dstE !== RN) begin fails++; $display("FAIL midrun_reset_M got %h/%h/%h want 1/0/f", M_icode, M_valE, M_dstE); end
    checks++; if (cc_out !== 3'b100) begin fails++; $display("FAIL midrun_reset_cc got %b want 100", cc_out); end
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_adr;
    test_cmov;
    test_stall_bubble;
    test_misc_alu;
    test_mulq;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
